pipeline_ctrl: RTL

// Central hazard/sequencing controller for the 5-stage pipeline. Drives the load-enable
// and flush (bubble-insert) controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.

---
 rtl/pipeline_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: per-stage load enables and
// bubble flushes, memory-wait handling with timeout trap, and stall/flush perf counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned TO_W   = 8,
  parameter int unsigned MEM_TO = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_is_load,
  input  logic             i_ex_br_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_en,
  output logic             o_pc_redirect,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_en,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_flush,
  output logic             o_trap,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  localparam logic            TO_EN   = (MEM_TO != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TO - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [TO_W-1:0]  w_to_cnt_nxt;
  logic             r_trap;
  logic             w_trap_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_mem_stall;
  logic             w_load_use;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_stall_inc;
  logic             w_flush_inc;

  assign w_mem_stall = i_mem_req & ~i_mem_ready;
  assign w_rs1_hit   = i_id_uses_rs1 & (i_id_rs1_addr == i_ex_rd_addr);
  assign w_rs2_hit   = i_id_uses_rs2 & (i_id_rs2_addr == i_ex_rd_addr);
  assign w_load_use  = i_ex_is_load & (i_ex_rd_addr != 5'd0) & (w_rs1_hit | w_rs2_hit);

  // State, timeout counter and sticky trap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_to_cnt <= '0;
      r_trap   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_cnt_nxt;
      r_trap   <= w_trap_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_to_cnt_nxt = r_to_cnt;
    w_trap_nxt   = r_trap;
    case (r_state)
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        if (w_mem_stall) begin
          if (TO_EN && (r_to_cnt == TO_LAST)) begin
            w_state_nxt = ST_HALT;
            w_trap_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_MEM_WAIT;
          end
          if (r_to_cnt != '1) w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end else begin
          // Ready (or no access) resolves the wait; this cycle runs the normal rules.
          w_state_nxt  = ST_RUN;
          w_to_cnt_nxt = '0;
        end
      end
    endcase
  end

  // Pipeline controls: zero-latency decode of state, hazards and reset
  always_comb begin
    o_pc_en        = 1'b1;
    o_pc_redirect  = 1'b0;
    o_if_id_en     = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_en     = 1'b1;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_en    = 1'b1;
    o_mem_wb_flush = 1'b0;
    if (rst) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_en     = 1'b0;
      o_id_ex_flush  = 1'b1;
      o_ex_mem_en    = 1'b0;
      o_mem_wb_flush = 1'b1;
    end else if (r_state == ST_HALT) begin
      o_pc_en     = 1'b0;
      o_if_id_en  = 1'b0;
      o_id_ex_en  = 1'b0;
      o_ex_mem_en = 1'b0;
    end else if (w_mem_stall) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_id_ex_en     = 1'b0;
      o_ex_mem_en    = 1'b0;
      o_mem_wb_flush = 1'b1;
    end else if (i_ex_br_taken) begin
      // ID holds a wrong-path instruction, so any load-use match is moot.
      o_pc_redirect = 1'b1;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
    end
  end

  assign w_stall_inc = (r_state != ST_HALT) & ~o_pc_en;
  assign w_flush_inc = o_pc_redirect;

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_trap      = r_trap;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule
